// File: rtl/wbb_pkg.sv
// Shared types for the write-back buffer: FSM state, entry layout and the
// word-address boundary used by every address compare.
package wbb_pkg;
    localparam int WORD_LSB   = 2;
    localparam int WBB_ADDR_W = 32;
    localparam int WBB_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, DRAIN, FORCE} wbb_state_t;

    typedef struct packed {
        logic                  valid;
        logic [WBB_ADDR_W-1:0] addr;
        logic [WBB_DATA_W-1:0] data;
    } wbb_entry_t;
endpackage

// File: rtl/wbb_match.sv
// Parallel word-address compare across all buffer entries; the youngest
// matching entry (furthest from the head) wins.
module wbb_match #(
    parameter int DEPTH = 4,
    parameter int WW    = 30,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         i_valid,
    input  logic [DEPTH-1:0][WW-1:0] i_word,
    input  logic [DEPTH-1:0][DW-1:0] i_data,
    input  logic [PW-1:0]            i_head,
    input  logic [WW-1:0]            i_key,
    output logic                     o_hit,
    output logic [PW-1:0]            o_idx,
    output logic [DW-1:0]            o_data
);
    logic [PW-1:0] w_j;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        o_data = '0;
        w_j    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_j = i_head + PW'(k);
            if (i_valid[w_j] && i_word[w_j] == i_key) begin
                o_hit  = 1'b1;
                o_idx  = w_j;
                o_data = i_data[w_j];
            end
        end
    end
endmodule

// File: rtl/write_back_buffer.sv
// Word-granular write-back FIFO between the cache and DataMemory: absorbs
// evictions, coalesces same-word writes, forwards to misses, drains when idle.
module write_back_buffer
    import wbb_pkg::*;
#(
    parameter int DATA_WIDTH = WBB_DATA_W,
    parameter int ADDR_WIDTH = WBB_ADDR_W,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid_i,
    input  logic [ADDR_WIDTH-1:0]    wb_addr_i,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    output logic                     wb_ready_o,
    input  logic [ADDR_WIDTH-1:0]    lookup_addr_i,
    output logic                     fwd_hit_o,
    output logic [DATA_WIDTH-1:0]    fwd_data_o,
    input  logic                     mem_rd_req_i,
    output logic                     rd_stall_o,
    input  logic                     flush_i,
    output logic                     mem_we_o,
    output logic [ADDR_WIDTH-1:0]    mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wd_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = ADDR_WIDTH - WORD_LSB;

    wbb_state_t  r_state;
    wbb_entry_t  r_ent [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;

    logic w_empty, w_full, w_fire, w_push, w_coal, w_append;
    logic [CW-1:0] w_cnt_nxt;
    logic [DEPTH-1:0] w_valid, w_cvalid;
    logic [DEPTH-1:0][WW-1:0] w_word;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_data;
    logic w_c_hit, w_l_hit;
    logic [PW-1:0] w_c_idx, w_l_idx;
    logic [DATA_WIDTH-1:0] w_c_data, w_l_data;
    logic w_unused;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_fire  = !w_empty && (r_state == FORCE || !mem_rd_req_i);
    assign w_push  = wb_valid_i && wb_ready_o;
    // The popping head is excluded so a rewrite of it lands in a fresh entry.
    assign w_coal   = w_push && w_c_hit;
    assign w_append = w_push && !w_c_hit;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i]  = r_ent[i].valid;
            w_cvalid[i] = r_ent[i].valid && !(w_fire && r_head == PW'(i));
            w_word[i]   = r_ent[i].addr[ADDR_WIDTH-1:WORD_LSB];
            w_data[i]   = r_ent[i].data;
        end
    end

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_append && !w_fire)
            w_cnt_nxt = r_count + 1'b1;
        else if (!w_append && w_fire)
            w_cnt_nxt = r_count - 1'b1;
    end

    wbb_match #(.DEPTH(DEPTH), .WW(WW), .DW(DATA_WIDTH)) u_coal (
        .i_valid (w_cvalid),
        .i_word  (w_word),
        .i_data  (w_data),
        .i_head  (r_head),
        .i_key   (wb_addr_i[ADDR_WIDTH-1:WORD_LSB]),
        .o_hit   (w_c_hit),
        .o_idx   (w_c_idx),
        .o_data  (w_c_data)
    );

    wbb_match #(.DEPTH(DEPTH), .WW(WW), .DW(DATA_WIDTH)) u_lookup (
        .i_valid (w_valid),
        .i_word  (w_word),
        .i_data  (w_data),
        .i_head  (r_head),
        .i_key   (lookup_addr_i[ADDR_WIDTH-1:WORD_LSB]),
        .o_hit   (w_l_hit),
        .o_idx   (w_l_idx),
        .o_data  (w_l_data)
    );

    assign w_unused = ^{w_c_data, w_l_idx, lookup_addr_i[WORD_LSB-1:0]};

    assign wb_ready_o = !w_full || w_fire;
    assign mem_we_o   = w_fire;
    assign mem_addr_o = w_empty ? '0 : r_ent[r_head].addr;
    assign mem_wd_o   = w_empty ? '0 : r_ent[r_head].data;
    assign rd_stall_o = (r_state == FORCE) && mem_rd_req_i && !w_empty;
    assign fwd_hit_o  = w_l_hit;
    assign fwd_data_o = w_l_data;
    assign count_o    = r_count;
    assign empty_o    = w_empty;
    assign full_o     = w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_ent[i] <= '0;
        end else begin
            // Pop clears first so an append into the same slot (full + pop) wins.
            if (w_fire) begin
                r_ent[r_head].valid <= 1'b0;
                r_head <= r_head + 1'b1;
            end
            if (w_coal)
                r_ent[w_c_idx].data <= wb_data_i;
            if (w_append) begin
                r_ent[r_tail].valid <= 1'b1;
                r_ent[r_tail].addr  <= wb_addr_i;
                r_ent[r_tail].data  <= wb_data_i;
                r_tail <= r_tail + 1'b1;
            end
            r_count <= w_cnt_nxt;
            case (r_state)
                IDLE:  if (w_push) r_state <= DRAIN;
                DRAIN: begin
                    if (w_cnt_nxt == '0)          r_state <= IDLE;
                    else if (w_full || flush_i)   r_state <= FORCE;
                end
                FORCE: begin
                    if (w_cnt_nxt == '0)          r_state <= IDLE;
                    else if (w_cnt_nxt < CW'(DEPTH) && !flush_i) r_state <= DRAIN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_write_back_buffer.sv
// Random + directed bench for write_back_buffer; a queue-based reference model
// predicts status outputs and DataMemory writes, which a monitor scoreboards.
module tb_write_back_buffer;
    localparam int DW = 32, AW = 32, DEPTH = 4, CW = 3;

    logic clk = 1'b0;
    logic rst, wb_valid_i, mem_rd_req_i, flush_i;
    logic [AW-1:0] wb_addr_i, lookup_addr_i, mem_addr_o;
    logic [DW-1:0] wb_data_i, fwd_data_o, mem_wd_o;
    logic wb_ready_o, fwd_hit_o, rd_stall_o, mem_we_o, empty_o, full_o;
    logic [CW-1:0] count_o;

    always #5 clk = ~clk;

    write_back_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .wb_ready_o(wb_ready_o), .lookup_addr_i(lookup_addr_i),
        .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
        .mem_rd_req_i(mem_rd_req_i), .rd_stall_o(rd_stall_o), .flush_i(flush_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
    ent_t mq[$];     // model buffer contents, oldest first
    ent_t sb[$];     // expected DataMemory writes
    ent_t mon_e;
    bit   forced;    // model: drain currently outranks reads
    int   n_chk = 0, n_fail = 0;

    function automatic bit same_word(logic [AW-1:0] x, logic [AW-1:0] y);
        return (x >> 2) == (y >> 2);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every DataMemory write must match the next predicted one.
    initial forever begin
        @(negedge clk);
        if (!rst && mem_we_o) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL mem_write: unexpected write addr %0h data %0h", mem_addr_o, mem_wd_o);
            end else begin
                mon_e = sb.pop_front();
                if (mem_addr_o !== mon_e.a || mem_wd_o !== mon_e.d) begin
                    n_fail++;
                    $display("FAIL mem_write: got %0h/%0h expected %0h/%0h",
                             mem_addr_o, mem_wd_o, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic cycle(bit v, logic [AW-1:0] a, logic [DW-1:0] d, bit rq, bit fl,
                         logic [AW-1:0] la);
        int sz, mi;
        bit fire, ready, push, hit, full_before;
        logic [DW-1:0] fd;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        @(posedge clk); #1;
        wb_valid_i = v; wb_addr_i = a; wb_data_i = d;
        mem_rd_req_i = rq; flush_i = fl; lookup_addr_i = la;
        sz = mq.size();
        fire  = (sz > 0) && (forced || !rq);
        ready = (sz < DEPTH) || fire;
        push  = v && ready;
        if (fire) sb.push_back(mq[0]);
        hit = 1'b0; fd = '0;
        for (int i = sz - 1; i >= 0; i--)
            if (!hit && same_word(mq[i].a, la)) begin hit = 1'b1; fd = mq[i].d; end
        ha = (sz > 0) ? mq[0].a : '0;
        hd = (sz > 0) ? mq[0].d : '0;
        @(negedge clk); #1;
        chk("count", count_o, sz);
        chk("empty", empty_o, sz == 0);
        chk("full", full_o, sz == DEPTH);
        chk("wb_ready", wb_ready_o, ready);
        chk("mem_we", mem_we_o, fire);
        chk("rd_stall", rd_stall_o, forced && rq && sz > 0);
        chk("head", {mem_addr_o, mem_wd_o}, {ha, hd});
        chk("fwd_hit", fwd_hit_o, hit);
        chk("fwd_data", fwd_data_o, fd);
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL mem_write: expected write %0h/%0h not seen", sb[0].a, sb[0].d);
            sb.delete();
        end
        full_before = (sz == DEPTH);
        if (fire) void'(mq.pop_front());
        if (push) begin
            mi = -1;
            foreach (mq[i]) if (same_word(mq[i].a, a)) mi = i;
            if (mi >= 0) mq[mi].d = d;
            else mq.push_back('{a: a, d: d});
        end
        if (sz == 0 || mq.size() == 0) forced = 1'b0;
        else if (!forced) forced = full_before || fl;
        else forced = !(mq.size() < DEPTH && !fl);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; wb_valid_i = 0; mem_rd_req_i = 0; flush_i = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete(); sb.delete(); forced = 1'b0;
    endtask

    task automatic idle_drain(int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 0, 32'h100);
    endtask

    initial begin
        bit fl;
        logic [AW-1:0] ra, rl;
        rst = 1'b1; wb_valid_i = 0; wb_addr_i = '0; wb_data_i = '0;
        mem_rd_req_i = 0; flush_i = 0; lookup_addr_i = '0;
        forced = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single push then drain on the next cycle.
        cycle(1, 32'h100, 32'hAAAA, 0, 0, 32'h100);
        cycle(0, '0, '0, 0, 0, 32'h100);
        cycle(0, '0, '0, 0, 0, 32'h100);

        // Coalesce same word at different byte offset; forward newest data.
        cycle(1, 32'h100, 32'h1, 1, 0, 32'h0);
        cycle(1, 32'h102, 32'h2, 1, 0, 32'h100);
        cycle(0, '0, '0, 1, 0, 32'h100);
        idle_drain(3);

        // Fill while reads block the port, then push at full in FORCE.
        for (int i = 0; i < 4; i++) cycle(1, 32'h300 + i * 4, i, 1, 0, 32'h304);
        for (int i = 0; i < 3; i++) cycle(1, 32'h400 + i * 4, 32'h50 + i, 1, 0, 32'h300);
        idle_drain(6);

        // Rewrite of the popping head appends instead of coalescing.
        cycle(1, 32'h200, 32'h5, 1, 0, 32'h200);
        cycle(1, 32'h200, 32'h9, 0, 0, 32'h200);
        cycle(0, '0, '0, 0, 0, 32'h200);
        idle_drain(2);

        // Flush with reads pending.
        for (int i = 0; i < 3; i++) cycle(1, 32'h500 + i * 4, 32'h70 + i, 1, 0, 32'h0);
        for (int i = 0; i < 8 && mq.size() > 0; i++) cycle(0, '0, '0, 1, 1, 32'h504);
        cycle(0, '0, '0, 1, 0, 32'h504);

        // Reset mid-drain discards everything.
        for (int i = 0; i < 3; i++) cycle(1, 32'h600 + i * 4, 32'h80 + i, 1, 0, 32'h0);
        cycle(0, '0, '0, 0, 0, 32'h604);
        do_reset();
        cycle(0, '0, '0, 0, 0, 32'h608);

        // Random traffic over a small word pool to exercise coalescing.
        fl = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (fl && mq.size() == 0) fl = 1'b0;
            else if (!fl && $urandom_range(0, 39) == 0) fl = 1'b1;
            ra = 32'h800 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            rl = 32'h800 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            cycle($urandom_range(0, 1), ra, $urandom, $urandom_range(0, 2) == 0, fl, rl);
        end
        idle_drain(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
